// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared state encoding, default widths and statistics helpers
//               for the direct-mapped write-through cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int c_DEF_IW  = 6;   // index width (ssram address width)
    localparam int c_DEF_TW  = 12;  // tag width
    localparam int c_DEF_DW  = 32;  // data word width
    localparam int c_STAT_W  = 16;  // hit/miss counter width

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_FILL   = 3'd2,
        S_RESP   = 3'd3,
        S_WRITE  = 3'd4
    } state_t;

    // Saturating increment for the statistics counters
    function automatic logic [c_STAT_W-1:0] sat_inc(input logic [c_STAT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(c_STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_tag_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_tag_array
// Description : Valid bits and tags for a direct-mapped cache. One
//               combinational lookup port (index, tag -> hit) and one
//               update port that marks a line valid with a new tag.
//               Valid bits clear on reset; tag storage is not reset because
//               the valid bits guard it.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_tag_array
#(
    parameter int IW = 6,
    parameter int TW = 12
)(
    input  logic          clk,
    input  logic          resetn,
    input  logic [IW-1:0] i_lk_idx,
    input  logic [TW-1:0] i_lk_tag,
    output logic          o_hit,
    input  logic          i_upd_en,
    input  logic [IW-1:0] i_upd_idx,
    input  logic [TW-1:0] i_upd_tag
);

    localparam int c_LINES = 1 << IW;

    logic [c_LINES-1:0] r_valid;
    logic [TW-1:0]      r_tag [0:c_LINES-1];

    // Valid bits: cleared asynchronously, set by a line fill
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
        end else if (i_upd_en) begin
            r_valid[i_upd_idx] <= 1'b1;
        end
    end

    // Tag storage: written alongside the valid bit, no reset needed
    always_ff @(posedge clk) begin
        if (i_upd_en) begin
            r_tag[i_upd_idx] <= i_upd_tag;
        end
    end

    // Hit requires a valid line whose stored tag matches
    always_comb begin
        o_hit = r_valid[i_lk_idx] && (r_tag[i_lk_idx] == i_lk_tag);
    end

endmodule : cache_tag_array
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl
// Description : Direct-mapped, write-through, no-write-allocate cache
//               controller with one-word lines. Data lives in an external
//               single-port ssram with a registered read address; tags and
//               valid bits live in cache_tag_array. Misses and all writes
//               go to the backing memory, one request outstanding at a time.
//               Optional feature macro: CACHE_STATS_EN adds saturating
//               read hit/miss counters on oHitCnt / oMissCnt.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int IW = c_DEF_IW,
    parameter int TW = c_DEF_TW,
    parameter int DW = c_DEF_DW
)(
    input  logic             clk,
    input  logic             resetn,
    // CPU side
    input  logic             iCpuReq,
    input  logic             iCpuWr,
    input  logic [TW+IW-1:0] iCpuAddr,
    input  logic [DW-1:0]    iCpuData,
    output logic             oCpuReady,
    output logic             oCpuRdValid,
    output logic [DW-1:0]    oCpuRdData,
    // ssram side
    output logic             oRamEnable,
    output logic             oRamWr,
    output logic [IW-1:0]    oRamAddr,
    output logic [DW-1:0]    oRamData,
    input  logic [DW-1:0]    iRamData,
    // backing memory side
    output logic             oMemReq,
    output logic             oMemWr,
    output logic [TW+IW-1:0] oMemAddr,
    output logic [DW-1:0]    oMemData,
    input  logic             iMemAck,
    input  logic [DW-1:0]    iMemData
`ifdef CACHE_STATS_EN
    ,
    output logic [c_STAT_W-1:0] oHitCnt,
    output logic [c_STAT_W-1:0] oMissCnt
`endif
);

    localparam int AW = TW + IW;

    state_t          r_state;
    logic [AW-1:0]   r_addr;      // latched request address
    logic            r_wr;        // latched request direction
    logic [DW-1:0]   r_data;      // latched write data
    logic [DW-1:0]   r_fill;      // word captured from memory on a fill
    logic [DW-1:0]   r_rd_data;   // last delivered read word (held output)

    logic            w_idle;
    logic            w_accept;
    logic            w_hit;
    logic            w_wr_hit;
    logic [IW-1:0]   w_lk_idx;
    logic [TW-1:0]   w_lk_tag;
    logic            w_upd_en;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && iCpuReq;
    assign w_wr_hit = w_accept && iCpuWr && w_hit;
    assign w_upd_en = (r_state == S_RESP);

    // In IDLE the lookup sees the incoming request (write-hit detection);
    // otherwise it sees the latched request.
    always_comb begin
        w_lk_idx = r_addr[IW-1:0];
        w_lk_tag = r_addr[AW-1:IW];
        if (w_idle) begin
            w_lk_idx = iCpuAddr[IW-1:0];
            w_lk_tag = iCpuAddr[AW-1:IW];
        end
    end

    cache_tag_array #(
        .IW (IW),
        .TW (TW)
    ) u_tag (
        .clk       (clk),
        .resetn    (resetn),
        .i_lk_idx  (w_lk_idx),
        .i_lk_tag  (w_lk_tag),
        .o_hit     (w_hit),
        .i_upd_en  (w_upd_en),
        .i_upd_idx (r_addr[IW-1:0]),
        .i_upd_tag (r_addr[AW-1:IW])
    );

    // Controller FSM with request latch and captured read/fill words
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_data    <= '0;
            r_fill    <= '0;
            r_rd_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= iCpuAddr;
                        r_wr    <= iCpuWr;
                        r_data  <= iCpuData;
                        r_state <= iCpuWr ? S_WRITE : S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_rd_data <= iRamData;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (iMemAck) begin
                        r_fill  <= iMemData;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rd_data <= r_fill;
                    r_state   <= S_IDLE;
                end
                S_WRITE: begin
                    if (iMemAck) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // CPU-side outputs: read data is forwarded in the delivering cycle and
    // held from the registered copy otherwise
    always_comb begin
        oCpuReady   = w_idle;
        oCpuRdValid = 1'b0;
        oCpuRdData  = r_rd_data;
        if ((r_state == S_LOOKUP) && w_hit) begin
            oCpuRdValid = 1'b1;
            oCpuRdData  = iRamData;
        end else if (r_state == S_RESP) begin
            oCpuRdValid = 1'b1;
            oCpuRdData  = r_fill;
        end
    end

    // ssram port: read on read acceptance, write on write hit or line fill
    always_comb begin
        oRamEnable = 1'b0;
        oRamWr     = 1'b0;
        oRamAddr   = '0;
        oRamData   = '0;
        if (w_accept && (!iCpuWr || w_hit)) begin
            oRamEnable = 1'b1;
            oRamWr     = w_wr_hit;
            oRamAddr   = iCpuAddr[IW-1:0];
            if (w_wr_hit) begin
                oRamData = iCpuData;
            end
        end else if (r_state == S_RESP) begin
            oRamEnable = 1'b1;
            oRamWr     = 1'b1;
            oRamAddr   = r_addr[IW-1:0];
            oRamData   = r_fill;
        end
    end

    // Backing memory port: request held for the whole FILL/WRITE state
    always_comb begin
        oMemReq  = (r_state == S_FILL) || (r_state == S_WRITE);
        oMemWr   = (r_state == S_WRITE) && r_wr;
        oMemAddr = r_addr;
        oMemData = r_data;
    end

`ifdef CACHE_STATS_EN
    logic [c_STAT_W-1:0] r_hit_cnt;
    logic [c_STAT_W-1:0] r_miss_cnt;

    // Saturating read hit/miss counters, sampled on the lookup cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                r_hit_cnt  <= sat_inc(r_hit_cnt);
            end else begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

    assign oHitCnt  = r_hit_cnt;
    assign oMissCnt = r_miss_cnt;
`endif

endmodule : cache_ctrl
`default_nettype wire
